// File: rtl/wta_leaky_n_if.sv
// Sample-in / result-out bundle for wta_leaky_n. The master drives samples and
// control; the slave (the WTA stage) returns the registered winner result.
interface wta_leaky_n_if #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 4
);
    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH*W-1:0] current;
    logic              in_valid;
    logic              mode;
    logic              clear;
    logic [N_CH*W-1:0] u_out;
    logic [IDX_W-1:0]  winner_idx;
    logic [N_CH-1:0]   winner_onehot;
    logic              out_valid;

    modport master (
        output current, in_valid, mode, clear,
        input  u_out, winner_idx, winner_onehot, out_valid
    );

    modport slave (
        input  current, in_valid, mode, clear,
        output u_out, winner_idx, winner_onehot, out_valid
    );
endinterface

// File: rtl/wta_leaky_n.sv
// N-channel winner-take-all with leaky accumulators and hysteresis.
// Stage 1 updates the accumulators; stage 2 resolves the winner and drives its lane.
module wta_leaky_n #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned W          = 4,
    parameter int unsigned ACC_W      = 8,
    parameter int unsigned LEAK_SHIFT = 2,
    parameter int unsigned HYST       = 2
) (
    input logic          clk,
    input logic          rst_n,
    wta_leaky_n_if.slave bus
);
    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [ACC_W:0] HYST_EXT = (ACC_W+1)'(HYST);

    // Stage 1 state
    logic [ACC_W-1:0]  acc_q [N_CH];
    logic [ACC_W-1:0]  acc_d [N_CH];
    logic [ACC_W:0]    sum   [N_CH];
    logic [N_CH*W-1:0] sample_q;
    logic              s1_valid_q;

    // Stage 2 state
    logic              has_winner_q;
    logic [IDX_W-1:0]  winner_idx_q;
    logic [N_CH-1:0]   onehot_q;
    logic [N_CH*W-1:0] u_out_q;
    logic              out_valid_q;

    logic [IDX_W-1:0]  chal;
    logic [ACC_W-1:0]  best;
    logic              take_over;
    logic [IDX_W-1:0]  next_idx;
    logic [N_CH*W-1:0] u_out_d;
    logic [N_CH-1:0]   onehot_d;

    // One extra bit of headroom lets the leaky sum saturate instead of wrapping.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            sum[i] = {1'b0, acc_q[i]} - ({1'b0, acc_q[i]} >> LEAK_SHIFT)
                   + (ACC_W+1)'(bus.current[i*W +: W]);
            if (!bus.mode) begin
                acc_d[i] = ACC_W'(bus.current[i*W +: W]);
            end else if (sum[i][ACC_W]) begin
                acc_d[i] = '1;
            end else begin
                acc_d[i] = sum[i][ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) acc_q[i] <= '0;
            sample_q   <= '0;
            s1_valid_q <= 1'b0;
        end else if (bus.clear) begin
            for (int i = 0; i < N_CH; i++) acc_q[i] <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                acc_q    <= acc_d;
                sample_q <= bus.current;
            end
        end
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        chal = '0;
        best = acc_q[0];
        for (int i = 1; i < N_CH; i++) begin
            if (acc_q[i] > best) begin
                best = acc_q[i];
                chal = IDX_W'(i);
            end
        end
    end

    always_comb begin
        take_over = {1'b0, acc_q[chal]} > ({1'b0, acc_q[winner_idx_q]} + HYST_EXT);
        next_idx  = winner_idx_q;
        if (!has_winner_q || ((chal != winner_idx_q) && take_over)) begin
            next_idx = chal;
        end
        u_out_d  = '0;
        onehot_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (next_idx == IDX_W'(i)) begin
                u_out_d[i*W +: W] = sample_q[i*W +: W];
                onehot_d[i]       = 1'b1;
            end
        end
    end

    // winner_idx_q doubles as the incumbent; clear only drops has_winner so outputs hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            has_winner_q <= 1'b0;
            winner_idx_q <= '0;
            onehot_q     <= '0;
            u_out_q      <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            out_valid_q <= s1_valid_q & ~bus.clear;
            if (bus.clear) begin
                has_winner_q <= 1'b0;
            end else if (s1_valid_q) begin
                has_winner_q <= 1'b1;
                winner_idx_q <= next_idx;
                onehot_q     <= onehot_d;
                u_out_q      <= u_out_d;
            end
        end
    end

    assign bus.u_out         = u_out_q;
    assign bus.winner_idx    = winner_idx_q;
    assign bus.winner_onehot = onehot_q;
    assign bus.out_valid     = out_valid_q;
endmodule

// File: tb/tb_wta_leaky_n.sv
// Bench for wta_leaky_n: directed vector table on two 4-channel instances, hand-written
// gap/clear/reset sequences, and a randomised 8-channel run against a reference model.
module tb_wta_leaky_n;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    wta_leaky_n_if #(.N_CH(4), .W(4)) if_a ();
    wta_leaky_n_if #(.N_CH(4), .W(4)) if_b ();
    wta_leaky_n_if #(.N_CH(8), .W(4)) if_r ();

    wta_leaky_n #(.N_CH(4), .W(4), .ACC_W(8), .LEAK_SHIFT(2), .HYST(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a)
    );
    wta_leaky_n #(.N_CH(4), .W(4), .ACC_W(5), .LEAK_SHIFT(2), .HYST(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b)
    );
    wta_leaky_n #(.N_CH(8), .W(4), .ACC_W(5), .LEAK_SHIFT(2), .HYST(2)) dut_r (
        .clk(clk), .rst_n(rst_n), .bus(if_r)
    );

    typedef struct {
        logic        sel;      // 0: dut_a, 1: dut_b
        logic        clr;      // pulse clear for one cycle first
        logic [15:0] cur;
        logic        mode;
        int unsigned exp_idx;
        logic [15:0] exp_u;
        int unsigned exp_acc2;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input int n, input vec_t v);
        logic        ov;
        int unsigned idx;
        logic [3:0]  oh;
        logic [15:0] u;
        int unsigned acc2;
        if (v.clr) begin
            if (v.sel) if_b.clear = 1'b1;
            else if_a.clear = 1'b1;
            @(posedge clk); #1;
            if_a.clear = 1'b0;
            if_b.clear = 1'b0;
        end
        if (v.sel) begin
            if_b.current = v.cur; if_b.mode = v.mode; if_b.in_valid = 1'b1;
        end else begin
            if_a.current = v.cur; if_a.mode = v.mode; if_a.in_valid = 1'b1;
        end
        @(posedge clk); #1;
        if_a.in_valid = 1'b0;
        if_b.in_valid = 1'b0;
        @(posedge clk); #1;
        if (v.sel) begin
            ov = if_b.out_valid; idx = int'(if_b.winner_idx); oh = if_b.winner_onehot;
            u = if_b.u_out; acc2 = int'(dut_b.acc_q[2]);
        end else begin
            ov = if_a.out_valid; idx = int'(if_a.winner_idx); oh = if_a.winner_onehot;
            u = if_a.u_out; acc2 = int'(dut_a.acc_q[2]);
        end
        check($sformatf("vec%0d out_valid", n), ov, 1);
        check($sformatf("vec%0d winner_idx", n), idx, v.exp_idx);
        check($sformatf("vec%0d onehot", n), oh, 4'(1 << v.exp_idx));
        check($sformatf("vec%0d u_out", n), u, v.exp_u);
        check($sformatf("vec%0d acc2", n), acc2, v.exp_acc2);
    endtask

    // Reference model state for the randomised 8-channel instance (ACC_W=5, HYST=2).
    localparam int R_N = 8;
    localparam int R_MAX = 31;
    localparam int R_HYST = 2;
    int          m_acc [R_N];
    bit          m_has;
    int          m_win;
    bit          pend_v;
    int          pend_idx;
    logic [31:0] pend_u;
    bit          m_ov;
    int          m_idx;
    logic [31:0] m_u;
    logic [7:0]  m_oh;

    initial begin
        int leak_a[] = '{15, 27, 36, 42, 47, 51, 54, 56, 57, 58, 59, 60, 60};
        int leak_b[] = '{15, 27, 31, 31};
        vec_t v;
        logic [31:0] cur;
        bit iv, cl, md;
        int sv, chal, nib;
        logic [39:0] ma, da;

        if_a.current = '0; if_a.in_valid = 0; if_a.mode = 0; if_a.clear = 0;
        if_b.current = '0; if_b.in_valid = 0; if_b.mode = 0; if_b.clear = 0;
        if_r.current = '0; if_r.in_valid = 0; if_r.mode = 0; if_r.clear = 0;

        tbl.push_back('{1'b0, 1'b0, 16'h2995, 1'b0, 1, 16'h0090, 9});
        for (int k = 0; k < leak_a.size(); k++)
            tbl.push_back('{1'b0, k == 0, 16'h0F00, 1'b1, 2, 16'h0F00, leak_a[k]});
        tbl.push_back('{1'b1, 1'b0, 16'h0007, 1'b0, 0, 16'h0007, 0});
        tbl.push_back('{1'b1, 1'b0, 16'h0087, 1'b0, 0, 16'h0007, 0});
        tbl.push_back('{1'b1, 1'b0, 16'h00A7, 1'b0, 1, 16'h00A0, 0});
        for (int k = 0; k < leak_b.size(); k++)
            tbl.push_back('{1'b1, k == 0, 16'h0F00, 1'b1, 2, 16'h0F00, leak_b[k]});

        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset out_valid", if_a.out_valid, 0);
        check("reset onehot", if_a.winner_onehot, 0);
        check("reset u_out", if_a.u_out, 0);

        for (int n = 0; n < tbl.size(); n++) apply(n, tbl[n]);

        // Gaps: valid on cycles 0,1 only; results on 2,3, held through 5.
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("gap%0d out_valid", k), if_a.out_valid, (k == 2 || k == 3));
            if (k >= 2) begin
                check($sformatf("gap%0d winner_idx", k), if_a.winner_idx, (k == 2) ? 0 : 3);
                check($sformatf("gap%0d u_out", k), if_a.u_out,
                      (k == 2) ? 16'h0004 : 16'h8000);
            end
            if_a.in_valid = (k < 2);
            if_a.mode = 1'b0;
            if_a.current = (k == 0) ? 16'h1234 : 16'h8111;
            @(posedge clk); #1;
        end
        if_a.in_valid = 1'b0;

        // Clear beats in_valid: sample dropped, outputs hold, next result is fresh.
        if_b.clear = 1'b1; if_b.in_valid = 1'b1; if_b.mode = 1'b0; if_b.current = 16'h0500;
        @(posedge clk); #1;
        if_b.clear = 1'b0; if_b.in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check($sformatf("clr%0d out_valid", j), if_b.out_valid, 0);
            check($sformatf("clr%0d winner_idx", j), if_b.winner_idx, 2);
            check($sformatf("clr%0d u_out", j), if_b.u_out, 16'h0F00);
            if (j == 0) check("clr acc2", dut_b.acc_q[2], 0);
            @(posedge clk); #1;
        end
        v = '{1'b1, 1'b0, 16'h0021, 1'b0, 1, 16'h0020, 0};
        apply(100, v);

        // Asynchronous reset between edges with a sample in flight.
        if_a.current = 16'h4000; if_a.in_valid = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        if_a.in_valid = 1'b0;
        #1;
        check("arst u_out", if_a.u_out, 0);
        check("arst winner_idx", if_a.winner_idx, 0);
        check("arst onehot", if_a.winner_onehot, 0);
        check("arst out_valid", if_a.out_valid, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-rst out_valid", if_a.out_valid, 0);
        check("post-rst onehot", if_a.winner_onehot, 0);
        v = '{1'b1, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 0};
        apply(101, v);
        v = '{1'b0, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 0};
        apply(102, v);

        // Randomised run against a transaction-level model.
        for (int i = 0; i < R_N; i++) m_acc[i] = 0;
        m_has = 0; m_win = 0; pend_v = 0; pend_idx = 0; pend_u = '0;
        m_ov = 0; m_idx = 0; m_u = '0; m_oh = '0; md = 0;
        for (int c = 0; c < 600; c++) begin
            iv = ($urandom_range(0, 9) < 7);
            cl = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 19) == 0) md = ~md;
            sv = $urandom_range(0, 15);
            for (int i = 0; i < R_N; i++) begin
                case ($urandom_range(0, 3))
                    0: nib = 15;
                    1: nib = sv;
                    default: nib = $urandom_range(0, 15);
                endcase
                cur[i*4 +: 4] = 4'(nib);
            end
            if_r.current = cur; if_r.in_valid = iv; if_r.clear = cl; if_r.mode = md;
            @(posedge clk); #1;

            if (cl) begin
                for (int i = 0; i < R_N; i++) m_acc[i] = 0;
                pend_v = 0; m_has = 0; m_ov = 0;
            end else begin
                m_ov = pend_v;
                if (pend_v) begin
                    m_idx = pend_idx; m_u = pend_u; m_oh = 8'(1) << m_idx;
                end
                pend_v = iv;
                if (iv) begin
                    for (int i = 0; i < R_N; i++) begin
                        nib = int'(cur[i*4 +: 4]);
                        if (!md) m_acc[i] = nib;
                        else m_acc[i] = m_acc[i] - (m_acc[i] / 4) + nib;
                        if (m_acc[i] > R_MAX) m_acc[i] = R_MAX;
                    end
                    chal = 0;
                    for (int i = 1; i < R_N; i++) if (m_acc[i] > m_acc[chal]) chal = i;
                    if (!m_has || m_acc[chal] > m_acc[m_win] + R_HYST) m_win = chal;
                    m_has = 1;
                    pend_idx = m_win;
                    pend_u = '0;
                    pend_u[m_win*4 +: 4] = cur[m_win*4 +: 4];
                end
            end

            for (int i = 0; i < R_N; i++) begin
                ma[i*5 +: 5] = 5'(m_acc[i]);
                da[i*5 +: 5] = dut_r.acc_q[i];
            end
            check($sformatf("rnd%0d out_valid", c), if_r.out_valid, m_ov);
            check($sformatf("rnd%0d winner_idx", c), if_r.winner_idx, m_idx);
            check($sformatf("rnd%0d onehot", c), if_r.winner_onehot, m_oh);
            check($sformatf("rnd%0d u_out", c), if_r.u_out, m_u);
            check($sformatf("rnd%0d accs", c), da, ma);
        end
        if_r.in_valid = 1'b0; if_r.clear = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
